// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-approach traffic controller.
//   phase_e    : controller state / phase code driven on the phase output
//   lamp_map() : maps (phase, is_active_approach) to a {green, yellow, red}
//                triple so that every approach shows exactly one lamp
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_INVALID = 2'd3
  } phase_e;

  // Only the approach owning the phase shows green/yellow; all others red.
  function automatic logic [2:0] lamp_map(input phase_e ph, input logic is_active);
    logic [2:0] lamp;
    lamp = 3'b001;
    if (is_active) begin
      case (ph)
        PH_GREEN:  lamp = 3'b100;
        PH_YELLOW: lamp = 3'b010;
        default:   lamp = 3'b001;
      endcase
    end else begin
      lamp = 3'b001;
    end
    return lamp;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin finder.
//   eff        : in  NUM_DIR  effective request per approach
//   active_dir : in  DIR_W    approach owning the current/last green
//   next_dir   : out DIR_W    first requesting approach after active_dir
//   found      : out 1        any approach requesting
// The search order is active_dir+1, +2, ... with active_dir itself last.
module rr_next_dir #(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] eff,
  input  logic [DIR_W-1:0]   active_dir,
  output logic [DIR_W-1:0]   next_dir,
  output logic               found
);

  int   scan_idx;
  logic scan_hit;

  // Walk the approaches in rotation order and keep the first hit.
  always_comb begin
    next_dir = active_dir;
    found    = 1'b0;
    scan_idx = 0;
    scan_hit = 1'b0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      scan_idx = (int'(active_dir) + k) % NUM_DIR;
      scan_hit = ~found & eff[DIR_W'(scan_idx)];
      found    = found | scan_hit;
      next_dir = scan_hit ? DIR_W'(scan_idx) : next_dir;
    end
  end

endmodule

// File: rtl/multi_dir_traffic_controller.sv
// N-approach intersection controller with round-robin service.
//   clk        : in  1        system clock, rising edge
//   reset_n    : in  1        asynchronous active-low reset
//   car_detect : in  NUM_DIR  per-approach vehicle present (level)
//   green      : out NUM_DIR  green lamp per approach (registered)
//   yellow     : out NUM_DIR  yellow lamp per approach (registered)
//   red        : out NUM_DIR  red lamp per approach (registered)
//   phase      : out 2        current phase code (0 all-red, 1 green, 2 yellow)
//   active_dir : out DIR_W    approach owning the current/last green
module multi_dir_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALL_RED_T  = 2,
  parameter int AUTO_CYCLE = 0,
  parameter int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_DIR-1:0] car_detect,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [1:0]         phase,
  output logic [DIR_W-1:0]   active_dir
);

  // Reject parameter sets the timer cannot represent or that make no sense.
  if (NUM_DIR < 2 || DIR_W != $clog2(NUM_DIR)) begin : g_bad_dir
    $error("multi_dir_traffic_controller: NUM_DIR must be >= 2 and DIR_W must not be overridden");
  end
  if (GREEN_MIN < 1 || YELLOW_T < 1 || ALL_RED_T < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_timing
    $error("multi_dir_traffic_controller: illegal timing parameters");
  end
  if (GREEN_MAX >= (1 << CNT_W) || GREEN_MIN >= (1 << CNT_W) ||
      YELLOW_T >= (1 << CNT_W) || ALL_RED_T >= (1 << CNT_W)) begin : g_bad_width
    $error("multi_dir_traffic_controller: timing value does not fit in CNT_W");
  end

  // Timer thresholds are "last cycle of the phase" values: timer counts from 0.
  localparam logic [CNT_W-1:0]   GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0]   GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0]   Y_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]   AR_LAST   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0]   TIMER_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   TIMER_ONE = CNT_W'(1);
  localparam logic [NUM_DIR-1:0] AUTO_MASK = (AUTO_CYCLE != 0) ? {NUM_DIR{1'b1}} : {NUM_DIR{1'b0}};
  localparam logic [NUM_DIR-1:0] ONE_DIR   = NUM_DIR'(1);

  phase_e             state;
  logic [CNT_W-1:0]   timer;
  logic [NUM_DIR-1:0] req;

  phase_e             state_nxt;
  logic [DIR_W-1:0]   dir_nxt;
  logic [NUM_DIR-1:0] req_nxt;
  logic [NUM_DIR-1:0] green_nxt;
  logic [NUM_DIR-1:0] yellow_nxt;
  logic [NUM_DIR-1:0] red_nxt;
  logic [NUM_DIR-1:0] eff;
  logic [NUM_DIR-1:0] active_mask;
  logic [NUM_DIR-1:0] nxt_mask;
  logic               other;
  logic [DIR_W-1:0]   rr_dir;
  logic               rr_found;
  logic [2:0]         lamp_v;

  assign eff         = req | AUTO_MASK;
  assign active_mask = ONE_DIR << active_dir;
  assign nxt_mask    = ONE_DIR << dir_nxt;
  assign other       = |(eff & ~active_mask);
  assign phase       = state;

  rr_next_dir #(
    .NUM_DIR (NUM_DIR),
    .DIR_W   (DIR_W)
  ) u_rr (
    .eff        (eff),
    .active_dir (active_dir),
    .next_dir   (rr_dir),
    .found      (rr_found)
  );

  // Phase sequencing: rest in all-red, gap-out/max-out green, fixed yellow.
  always_comb begin
    state_nxt = state;
    dir_nxt   = active_dir;
    case (state)
      PH_ALL_RED: begin
        if (timer >= AR_LAST && rr_found) begin
          state_nxt = PH_GREEN;
          dir_nxt   = rr_dir;
        end else begin
          state_nxt = PH_ALL_RED;
        end
      end
      PH_GREEN: begin
        // Leave only when someone else waits; the owner's own car holds green up to max.
        if (timer >= GMIN_LAST && other && (!car_detect[active_dir] || timer >= GMAX_LAST)) begin
          state_nxt = PH_YELLOW;
        end else begin
          state_nxt = PH_GREEN;
        end
      end
      PH_YELLOW: begin
        if (timer >= Y_LAST) begin
          state_nxt = PH_ALL_RED;
        end else begin
          state_nxt = PH_YELLOW;
        end
      end
      default: begin
        state_nxt = PH_ALL_RED;
      end
    endcase
  end

  // Request latches: the green owner cannot re-request itself; serviced request clears on entry.
  always_comb begin
    req_nxt = req | (car_detect & ((state == PH_GREEN) ? ~active_mask : {NUM_DIR{1'b1}}));
    if (state_nxt == PH_GREEN && state != PH_GREEN) begin
      req_nxt = req_nxt & ~nxt_mask;
    end else begin
      req_nxt = req_nxt;
    end
  end

  // Lamp vectors for the upcoming cycle, registered below.
  always_comb begin
    green_nxt  = {NUM_DIR{1'b0}};
    yellow_nxt = {NUM_DIR{1'b0}};
    red_nxt    = {NUM_DIR{1'b0}};
    lamp_v     = 3'b001;
    for (int i = 0; i < NUM_DIR; i++) begin
      lamp_v        = lamp_map(state_nxt, DIR_W'(i) == dir_nxt);
      green_nxt[i]  = lamp_v[2];
      yellow_nxt[i] = lamp_v[1];
      red_nxt[i]    = lamp_v[0];
    end
  end

  // State, timer, request and lamp registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PH_ALL_RED;
      timer      <= {CNT_W{1'b0}};
      active_dir <= DIR_W'(NUM_DIR - 1);
      req        <= {NUM_DIR{1'b0}};
      green      <= {NUM_DIR{1'b0}};
      yellow     <= {NUM_DIR{1'b0}};
      red        <= {NUM_DIR{1'b1}};
    end else begin
      state      <= state_nxt;
      active_dir <= dir_nxt;
      req        <= req_nxt;
      green      <= green_nxt;
      yellow     <= yellow_nxt;
      red        <= red_nxt;
      if (state_nxt != state) begin
        timer <= {CNT_W{1'b0}};
      end else if (timer != TIMER_MAX) begin
        timer <= timer + TIMER_ONE;
      end else begin
        timer <= timer;
      end
    end
  end

endmodule

// File: tb/tb_multi_dir_traffic_controller.sv
// Self-checking bench: a cycle-level reference model of the intersection rules
// checks the demand-driven controller every cycle, and a closed-form slot
// schedule checks a second, auto-cycling instance.
module tb_multi_dir_traffic_controller;

  localparam int ND   = 4;
  localparam int GMIN = 8;
  localparam int GMAX = 20;
  localparam int YT   = 3;
  localparam int ART  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] car_detect = 4'h0;
  logic [3:0] auto_cars = 4'h0;
  logic [3:0] green, yellow, red;
  logic [1:0] phase, active_dir;
  logic [3:0] a_green, a_yellow, a_red;
  logic [1:0] a_phase, a_active_dir;

  int total = 0;
  int bad = 0;

  // reference model: phase (0 red,1 green,2 yellow), cycles spent in phase, owner, pending requests
  int         m_ph;
  int         m_el;
  int         m_dir;
  logic [3:0] m_req;
  int         auto_n;
  bit         auto_chk;

  always #5 clk = ~clk;

  multi_dir_traffic_controller #(
    .NUM_DIR(ND), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALL_RED_T(ART), .AUTO_CYCLE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .car_detect(car_detect),
    .green(green), .yellow(yellow), .red(red),
    .phase(phase), .active_dir(active_dir)
  );

  multi_dir_traffic_controller #(
    .NUM_DIR(ND), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALL_RED_T(ART), .AUTO_CYCLE(1)
  ) dut_auto (
    .clk(clk), .reset_n(reset_n), .car_detect(auto_cars),
    .green(a_green), .yellow(a_yellow), .red(a_red),
    .phase(a_phase), .active_dir(a_active_dir)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph  = 0;
    m_el  = 0;
    m_dir = ND - 1;
    m_req = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] cd);
    int         nph;
    int         ndir;
    bit         waiting;
    logic [1:0] d;
    nph  = m_ph;
    ndir = m_dir;
    if (m_ph == 0) begin
      if (m_el >= ART - 1) begin
        for (int k = 1; k <= ND; k++) begin
          d = 2'((m_dir + k) % ND);
          if (nph == 0 && m_req[d]) begin
            nph  = 1;
            ndir = int'(d);
          end
        end
      end
    end else if (m_ph == 1) begin
      waiting = 0;
      for (int j = 0; j < ND; j++) if (j != m_dir && m_req[j]) waiting = 1;
      if (m_el >= GMIN - 1 && waiting && (!cd[m_dir[1:0]] || m_el >= GMAX - 1)) nph = 2;
    end else begin
      if (m_el >= YT - 1) nph = 0;
    end
    for (int i = 0; i < ND; i++) if (cd[i] && !(m_ph == 1 && i == m_dir)) m_req[i] = 1'b1;
    if (nph == 1 && m_ph != 1) m_req[ndir[1:0]] = 1'b0;
    m_el  = (nph != m_ph) ? 0 : ((m_el < 255) ? m_el + 1 : 255);
    m_ph  = nph;
    m_dir = ndir;
  endtask

  function automatic logic [15:0] model_expect();
    logic [3:0] g, y;
    logic [1:0] dd;
    dd = m_dir[1:0];
    g = 4'h0;
    y = 4'h0;
    if (m_ph == 1) g[dd] = 1'b1;
    if (m_ph == 2) y[dd] = 1'b1;
    return {g, y, ~(g | y), 2'(m_ph), dd};
  endfunction

  // Auto-cycle schedule: 2 reset all-red cycles, then 13-cycle slots rotating 0,1,2,3.
  function automatic logic [15:0] auto_expect(input int n);
    int         m, off;
    logic [1:0] d;
    logic [3:0] oh;
    if (n < 2) return {4'h0, 4'h0, 4'hf, 2'd0, 2'd3};
    m   = n - 2;
    off = m % (GMIN + YT + ART);
    d   = 2'((m / (GMIN + YT + ART)) % ND);
    oh  = 4'b0001 << d;
    if (off < GMIN) return {oh, 4'h0, ~oh, 2'd1, d};
    else if (off < GMIN + YT) return {4'h0, oh, ~oh, 2'd2, d};
    else return {4'h0, 4'h0, 4'hf, 2'd0, d};
  endfunction

  task automatic tick(input logic [3:0] cd);
    car_detect = cd;
    @(posedge clk);
    model_step(cd);
    auto_n++;
    #1;
    check("cycle", {green, yellow, red, phase, active_dir}, model_expect());
    if (auto_chk) check("auto", {a_green, a_yellow, a_red, a_phase, a_active_dir}, auto_expect(auto_n));
  endtask

  function automatic logic [3:0] lamp(input int sel);
    case (sel)
      0:       return green;
      1:       return yellow;
      default: return red;
    endcase
  endfunction

  task automatic wait_lamp(input logic [3:0] cd, input int sel, input logic [3:0] pat, input string tag);
    int n;
    n = 0;
    while (lamp(sel) !== pat && n < 200) begin
      tick(cd);
      n++;
    end
    check(tag, {12'h0, lamp(sel)}, {12'h0, pat});
  endtask

  task automatic run_len(input logic [3:0] cd, input int sel, input logic [3:0] pat, output int n);
    n = 0;
    while (lamp(sel) === pat && n < 200) begin
      tick(cd);
      n++;
    end
  endtask

  initial begin
    int         lat;
    int         n;
    int         cnt;
    int         exp_order[3];
    logic [3:0] prev_g;
    logic [3:0] hold;
    logic [3:0] rnd;

    model_reset();
    auto_n   = 0;
    auto_chk = 1;
    repeat (2) @(negedge clk);
    check("reset", {green, yellow, red, phase, active_dir}, {4'h0, 4'h0, 4'hf, 2'd0, 2'd3});
    check("reset_auto", {a_green, a_yellow, a_red, a_phase, a_active_dir}, {4'h0, 4'h0, 4'hf, 2'd0, 2'd3});
    reset_n = 1'b1;

    // idle: demand-only controller rests in red, auto controller rotates
    repeat (120) tick(4'h0);
    auto_chk = 0;

    // single pulse on approach 2
    tick(4'b0100);
    lat = 1;
    while (green !== 4'b0100 && lat < 10) begin
      tick(4'h0);
      lat++;
    end
    check("pulse_latency", 16'(lat), 16'd2);
    repeat (30) tick(4'h0);
    check("green_hold", {12'h0, green}, {12'h0, 4'b0100});

    // hand over to approach 0: yellow 3, all-red 2
    tick(4'b0001);
    wait_lamp(4'h0, 1, 4'b0100, "yellow2_start");
    run_len(4'h0, 1, 4'b0100, n);
    check("yellow_len", 16'(n), 16'd3);
    run_len(4'h0, 2, 4'hf, n);
    check("allred_len", 16'(n), 16'd2);
    check("green0", {12'h0, green}, {12'h0, 4'b0001});

    // max-out: approach 1 held during its green with approach 3 waiting
    tick(4'b0010);
    wait_lamp(4'b0010, 0, 4'b0010, "green1_start");
    tick(4'b1010);
    run_len(4'b0010, 0, 4'b0010, n);
    check("maxout_len", 16'(n + 1), 16'd20);
    run_len(4'h0, 1, 4'b0010, n);
    check("maxout_yellow_len", 16'(n), 16'd3);
    run_len(4'h0, 2, 4'hf, n);
    check("maxout_allred_len", 16'(n), 16'd2);
    check("green3", {12'h0, green}, {12'h0, 4'b1000});

    // round-robin order from owner 0 with 0, 1, 3 pending: expect 1, 3, 0
    tick(4'b0001);
    wait_lamp(4'h0, 0, 4'b0001, "green0_start");
    tick(4'b1011);
    wait_lamp(4'b0001, 1, 4'b0001, "yellow0_start");
    tick(4'b0001);
    exp_order[0] = 1;
    exp_order[1] = 3;
    exp_order[2] = 0;
    cnt    = 0;
    n      = 0;
    prev_g = green;
    while (cnt < 3 && n < 300) begin
      tick(4'h0);
      n++;
      if (green !== 4'h0 && prev_g === 4'h0) begin
        check("rr_order", {14'h0, active_dir}, 16'(exp_order[cnt]));
        cnt++;
      end
      prev_g = green;
    end
    check("rr_order_count", 16'(cnt), 16'd3);

    // asynchronous reset in the middle of a yellow phase
    tick(4'b0100);
    wait_lamp(4'h0, 1, 4'b0001, "yellow_mid");
    tick(4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {green, yellow, red, phase, active_dir}, {4'h0, 4'h0, 4'hf, 2'd0, 2'd3});
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) tick(4'h0);
    check("rest_after_reset", {12'h0, red}, {12'h0, 4'hf});
    tick(4'b1000);
    wait_lamp(4'h0, 0, 4'b1000, "green_after_reset");

    // randomized traffic against the model
    hold = 4'h0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) hold = 4'($urandom_range(0, 15));
      rnd = 4'h0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rnd[b] = 1'b1;
      tick(hold | rnd);
    end
    repeat (60) tick(4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
